sysx_slave_port: RTL
====================

# sysx_slave_port

Peripheral-side endpoint of the sysX bus: it responds to frames issued by the sysX master controller. It follows the master's bus clock, select and 8-bit MOSI lanes, reassembles each 4-byte frame into a 32-bit word for local logic, and drives a local 32-bit word back onto the 8-bit MISO lanes in the same byte order. It sits in each sysX peripheral, between the backplane pins and the peripheral's register logic, and is fully synchronous to the peripheral's own clock.

## Interface
- SELECT_CODE, 2'd1: select value that addresses this port. Must be nonzero, because 0 means the bus is idle.
- FILL_WORD, 32'hFFFF_FFFF: word sent on MISO when no TX word is available.
- SYNC_STAGES, 2: synchronizer depth for iBusClock, iBusSelect and iBusMOSI.
- iClk in 1: peripheral clock.
- iReset in 1: reset, synchronous, active-high.
- iBusClock in 1: master bus clock. It idles high.
- iBusSelect in 2: master chip select.
- iBusMOSI in 8: master-to-slave byte lane.
- oBusMISO out 8: slave-to-master byte lane.
- oBusMISOEnable out 1: MISO drive enable, used for the external tristate.
- oBusInterrupt out 1: interrupt to the master.
- iIrq in 1: local interrupt request.
- iTxData in 32: next word to send.
- iTxValid in 1: iTxData is valid.
- oTxReady out 1: TX storage can accept a word.
- oRxData out 32: last received word.
- oRxValid out 1: one-cycle pulse when a word has been received.
- oTxUnderrun out 1: one-cycle pulse when a frame starts with no TX word available.
- oBusy out 1: a frame is in progress.

## Operation
- All bus inputs pass through SYNC_STAGES flops. Edge detect is done on the synchronized iBusClock.
- The port is addressed when the synchronized iBusSelect equals SELECT_CODE.
- States: IDLE, LOAD, B0, B1, B2, B3, STORE. These mirror the master's pipeline.
- IDLE → LOAD when the select becomes equal to SELECT_CODE.
  - On entry to LOAD, the front TX word is latched into the shift word and popped from TX storage.
  - If TX storage is empty, FILL_WORD is latched instead and oTxUnderrun pulses.
- Each synchronized bus-clock rising edge advances the state: LOAD→B0→B1→B2→B3→STORE.
- From STORE, the next rising edge goes to LOAD if the port is still addressed, otherwise to IDLE. This supports back-to-back block frames.
- In state Bn:
  - oBusMISO = shift word bits [8n+7:8n]. Byte 0 is the least significant.
  - oBusMISOEnable = 1.
- On each falling edge in state Bn, iBusMOSI is captured into RX byte n.
- On entry to STORE, oRxData is updated with the assembled word and oRxValid pulses.
- Every frame produces oRxValid, including master-receive frames where MOSI is 0xFF. Local logic decides whether the word is meaningful.
- Deselect in any non-IDLE state:
  - The frame is aborted and the state returns to IDLE.
  - There is no oRxValid. oRxData is unchanged.
  - The TX word latched for the aborted frame is lost.
- oBusInterrupt = iIrq, registered once.
- oBusMISO = 8'h00 and oBusMISOEnable = 0 in IDLE, LOAD and STORE.
- TX handshake: a word is accepted when iTxValid && oTxReady on a rising iClk edge.
- A push and a pop in the same cycle are both honoured. A full store stays full.

## Timing
- Reset values: state IDLE; oBusMISO 0; oBusMISOEnable 0; oBusInterrupt 0; oRxData 0; oRxValid 0; oTxUnderrun 0; oBusy 0; oTxReady 1; TX storage empty.
- Reset mid-frame returns the state to IDLE on the next iClk edge. No oRxValid is produced.
- Latency from a raw bus edge to the state change is SYNC_STAGES+1 iClk cycles.
- oRxValid is asserted SYNC_STAGES+1 cycles after the raw rising edge that enters STORE.
- Requirement: each bus-clock level must last at least SYNC_STAGES+2 iClk cycles.
  - This guarantees MISO is stable before the master samples on the falling edge.
  - It also means MOSI is sampled after settling.
- oBusy is 1 in every state except IDLE.

## Configuration
- SYSX_SLAVE_TX_FIFO_EN defined: TX storage is a 4-entry FIFO with 3-bit occupancy.
  - oTxReady = occupancy < 4.
  - Up to four words may be queued for block transfers.
- SYSX_SLAVE_TX_FIFO_EN undefined: TX storage is a single holding register.
  - oTxReady = holding register empty.

## Structure
- Shared package sysx_pkg holds:
  - the state encoding (IDLE=0 … STORE=6, 3 bits), matching the master's pipeline numbering;
  - the byte-lane width (8) and word width (32);
  - the idle select code (2'd0).
- Sub-module sysx_word_fifo: parameterised depth, 32-bit, synchronous, with push/pop/full/empty.
  - It is instantiated with depth 4 under SYSX_SLAVE_TX_FIFO_EN and with depth 1 otherwise.

## Test plan
- Single frame: push iTxData 0x12345678, SELECT_CODE 1, MOSI bytes EF, BE, AD, DE → MISO bytes 78, 56, 34, 12; oRxData 0xDEADBEEF with one oRxValid pulse.
- Empty TX storage when a frame starts → oTxUnderrun pulses once; MISO bytes FF×4; oRxValid still pulses.
- iBusSelect = 2 with SELECT_CODE 1 → oBusMISOEnable stays 0; no oRxValid; TX word not popped.
- Deselect during B2 → state returns to IDLE; no oRxValid; oRxData retains its previous value.
- FIFO enabled, words 0xA0..0xA3 pushed, 4-frame block transfer → MISO shows A0, A1, A2, A3 in order; oTxReady drops at 4 queued and rises after the first pop.
- Assert iReset during B1 → next cycle: IDLE, oBusMISOEnable 0, oTxReady 1; the following full frame completes normally.

Source files
------------

// File: rtl/sysx_pkg.sv
// sysx_pkg: definitions shared by the sysX master and slave endpoints.
// The state numbering matches the master's pipeline stages.
package sysx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [1:0] SEL_IDLE = 2'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_B0    = 3'd2,
        ST_B1    = 3'd3,
        ST_B2    = 3'd4,
        ST_B3    = 3'd5,
        ST_STORE = 3'd6
    } sysx_state_t;

    function automatic logic isByteState(input sysx_state_t s);
        return (s == ST_B0) || (s == ST_B1) || (s == ST_B2) || (s == ST_B3);
    endfunction

    // Byte lane served in a byte state; byte 0 is the least significant.
    function automatic logic [1:0] byteIdx(input sysx_state_t s);
        return 2'(s - ST_B0);
    endfunction

    function automatic logic [BYTE_W-1:0] laneOf(input logic [WORD_W-1:0] word,
                                                 input logic [1:0] idx);
        return word[idx*BYTE_W +: BYTE_W];
    endfunction

endpackage

// File: rtl/sysx_slave_port_if.sv
// sysx_slave_port_if: sysX backplane signals seen by one peripheral.
// The master modport drives clock/select/MOSI; the slave modport drives MISO.
interface sysx_slave_port_if;
    import sysx_pkg::*;

    logic              iBusClock;
    logic [1:0]        iBusSelect;
    logic [BYTE_W-1:0] iBusMOSI;
    logic [BYTE_W-1:0] oBusMISO;
    logic              oBusMISOEnable;
    logic              oBusInterrupt;

    modport master (
        output iBusClock, iBusSelect, iBusMOSI,
        input  oBusMISO, oBusMISOEnable, oBusInterrupt
    );

    modport slave (
        input  iBusClock, iBusSelect, iBusMOSI,
        output oBusMISO, oBusMISOEnable, oBusInterrupt
    );
endinterface

// File: rtl/sysx_word_fifo.sv
// sysx_word_fifo: synchronous word FIFO of configurable depth.
// Push and pop in the same cycle are both honoured, so a full FIFO stays full.
module sysx_word_fifo
    import sysx_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iPush,
    input  logic [WORD_W-1:0] iData,
    input  logic              iPop,
    output logic [WORD_W-1:0] oData,
    output logic              oFull,
    output logic              oEmpty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              doPush;
    logic              doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign oFull  = (count == CNT_W'(DEPTH));
    assign oEmpty = (count == '0);
    assign oData  = mem[rdPtr];
    assign doPop  = iPop && !oEmpty;
    assign doPush = iPush && (!oFull || doPop);

    // Storage, pointers and occupancy.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= iData;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sysx_slave_port.sv
// sysx_slave_port: peripheral endpoint of the sysX bus. Reassembles 4-byte
// MOSI frames into words and returns a local TX word on MISO, LSB first.
// Optional build macro: SYSX_SLAVE_TX_FIFO_EN (4-entry TX FIFO instead of a
// single holding register).
module sysx_slave_port
    import sysx_pkg::*;
#(
    parameter logic [1:0]        SELECT_CODE = 2'd1,
    parameter logic [WORD_W-1:0] FILL_WORD   = 32'hFFFF_FFFF,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic                iClk,
    input  logic                iReset,
    sysx_slave_port_if.slave    bus,
    input  logic                iIrq,
    input  logic [WORD_W-1:0]   iTxData,
    input  logic                iTxValid,
    output logic                oTxReady,
    output logic [WORD_W-1:0]   oRxData,
    output logic                oRxValid,
    output logic                oTxUnderrun,
    output logic                oBusy
);

`ifdef SYSX_SLAVE_TX_FIFO_EN
    localparam int unsigned TX_DEPTH = 4;
`else
    localparam int unsigned TX_DEPTH = 1;
`endif

    logic [SYNC_STAGES-1:0] clkSync;
    logic [1:0]             selSync  [SYNC_STAGES];
    logic [BYTE_W-1:0]      mosiSync [SYNC_STAGES];
    logic                   clkPrev;
    logic                   clkS;
    logic [1:0]             selS;
    logic [BYTE_W-1:0]      mosiS;
    logic                   busRise;
    logic                   busFall;
    logic                   addressed;

    sysx_state_t            state;
    sysx_state_t            stateNext;
    logic [WORD_W-1:0]      shiftWord;
    logic [WORD_W-1:0]      rxBuf;
    logic                   enterLoad;
    logic                   enterStore;

    logic [WORD_W-1:0]      txData;
    logic                   txFull;
    logic                   txEmpty;
    logic                   txPush;
    logic                   txPop;

    assign clkS      = clkSync[SYNC_STAGES-1];
    assign selS      = selSync[SYNC_STAGES-1];
    assign mosiS     = mosiSync[SYNC_STAGES-1];
    assign busRise   = clkS && !clkPrev;
    assign busFall   = !clkS && clkPrev;
    assign addressed = (selS == SELECT_CODE);

    // Bus input synchronizers; the bus clock resets to its idle-high level.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            clkSync <= '1;
            clkPrev <= 1'b1;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                selSync[i]  <= SEL_IDLE;
                mosiSync[i] <= '0;
            end
        end else begin
            clkSync[0]  <= bus.iBusClock;
            selSync[0]  <= bus.iBusSelect;
            mosiSync[0] <= bus.iBusMOSI;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                clkSync[i]  <= clkSync[i-1];
                selSync[i]  <= selSync[i-1];
                mosiSync[i] <= mosiSync[i-1];
            end
            clkPrev <= clkS;
        end
    end

    // Frame sequencing: deselect aborts from any state, bus-clock rises advance.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (addressed) stateNext = ST_LOAD;
            end
            ST_STORE: begin
                if (!addressed)   stateNext = ST_IDLE;
                else if (busRise) stateNext = ST_LOAD;
            end
            default: begin
                if (!addressed)   stateNext = ST_IDLE;
                else if (busRise) stateNext = sysx_state_t'(state + 3'd1);
            end
        endcase
    end

    assign enterLoad  = (stateNext == ST_LOAD) && (state != ST_LOAD);
    assign enterStore = (stateNext == ST_STORE) && (state == ST_B3);
    assign txPop      = enterLoad && !txEmpty;
    assign oTxReady   = !txFull;
    assign txPush     = iTxValid && oTxReady;

    // State register, shift/RX words and registered bus/local outputs.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state              <= ST_IDLE;
            shiftWord          <= '0;
            rxBuf              <= '0;
            oRxData            <= '0;
            oRxValid           <= 1'b0;
            oTxUnderrun        <= 1'b0;
            oBusy              <= 1'b0;
            bus.oBusMISO       <= '0;
            bus.oBusMISOEnable <= 1'b0;
            bus.oBusInterrupt  <= 1'b0;
        end else begin
            state             <= stateNext;
            oBusy             <= (stateNext != ST_IDLE);
            oTxUnderrun       <= enterLoad && txEmpty;
            bus.oBusInterrupt <= iIrq;

            if (enterLoad) begin
                shiftWord <= txEmpty ? FILL_WORD : txData;
            end

            if (isByteState(state) && addressed && busFall) begin
                rxBuf[byteIdx(state)*BYTE_W +: BYTE_W] <= mosiS;
            end

            oRxValid <= enterStore;
            if (enterStore) begin
                oRxData <= rxBuf;
            end

            // MISO follows the state being entered so it is valid with that state.
            if (isByteState(stateNext)) begin
                bus.oBusMISO       <= laneOf(shiftWord, byteIdx(stateNext));
                bus.oBusMISOEnable <= 1'b1;
            end else begin
                bus.oBusMISO       <= '0;
                bus.oBusMISOEnable <= 1'b0;
            end
        end
    end

    sysx_word_fifo #(
        .DEPTH (TX_DEPTH)
    ) uTxStore (
        .iClk   (iClk),
        .iReset (iReset),
        .iPush  (txPush),
        .iData  (iTxData),
        .iPop   (txPop),
        .oData  (txData),
        .oFull  (txFull),
        .oEmpty (txEmpty)
    );

endmodule
